seq_divider: RTL

- Multi-cycle 32-bit integer divider for the RV32M execute stage.
- Implements DIV, DIVU, REM and REMU as the subtractive counterpart to the existing 32-bit ripple adder.
- Computes one restoring quotient bit per cycle. The adder is reused as the trial subtractor.
- Sits beside the ALU. The decode stage drives it through a valid/ready handshake, and writeback drains it.

---
 rtl/div_pkg.sv | 25 ++
 rtl/div_step.sv | 34 +++
 rtl/full_adder_32.sv | 23 ++
 rtl/seq_divider.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential RV32M divider.
// Contents: operation and FSM state enums, operand width, special-case result constants.
package div_pkg;

    localparam int unsigned XLEN = 32;

    // Encoding matches funct3[1:0] of DIV/DIVU/REM/REMU
    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        FIX,
        DONE
    } div_state_t;

    localparam logic [XLEN-1:0] DIV_ZERO_QUO = 32'hFFFF_FFFF;
    localparam logic [XLEN-1:0] INT_MIN      = 32'h8000_0000;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit and try to subtract the divisor.
// Ports: rem - partial remainder; bit_in - next dividend bit; divisor - divisor magnitude;
//        rem_next - updated remainder; quo_bit - quotient bit produced by this step.
module div_step
    import div_pkg::*;
(
    input  logic [XLEN-1:0] rem,
    input  logic            bit_in,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic            quo_bit
);

    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] trial;
    logic            no_borrow;

    assign shifted = {rem[XLEN-2:0], bit_in};

    // shifted - divisor as shifted + ~divisor + 1; carry out set means no borrow
    FullAdder_32 u_sub (
        .a   (shifted),
        .b   (~divisor),
        .cin (1'b1),
        .sum (trial),
        .cout(no_borrow)
    );

    // A set remainder MSB means the true shifted value is at least 2^XLEN, which always
    // exceeds the divisor; the wrapped trial difference is then the exact new remainder.
    assign quo_bit  = no_borrow | rem[XLEN-1];
    assign rem_next = quo_bit ? trial : shifted;

endmodule

// File: rtl/full_adder_32.sv
// 32-bit ripple-carry adder, reused by the divider as its trial subtractor.
// Ports: a, b - addends; cin - carry in; sum - a + b + cin; cout - carry out.
module FullAdder_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    // Bit-serial carry chain
    always_comb begin
        logic c;
        c   = cin;
        sum = '0;
        for (int i = 0; i < 32; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Ports: clk, reset (async, active high); in_valid/in_ready/op/dividend/divisor - request side;
//        out_valid/out_ready/result/div_by_zero - result side; busy - iterating or fixing signs.
// Optional: define SEQ_DIVIDER_EARLY_OUT_EN to skip the leading-zero iterations of the dividend.
module seq_divider
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             div_by_zero,
    output logic             busy
);

    div_state_t       state;
    div_op_t          op_q;
    logic             sign_a;
    logic             sign_b;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dsr_q;
    logic [CNT_W-1:0] cnt_q;

    logic [WIDTH-1:0] step_rem;
    logic             step_bit;

    div_step u_step (
        .rem     (rem_q),
        .bit_in  (quo_q[WIDTH-1]),
        .divisor (dsr_q),
        .rem_next(step_rem),
        .quo_bit (step_bit)
    );

    // Request decode, used only on the accept edge
    div_op_t          op_c;
    logic             accept_c;
    logic             signed_c;
    logic             neg_a_c;
    logic             neg_b_c;
    logic [WIDTH-1:0] mag_a_c;
    logic [WIDTH-1:0] mag_b_c;
    logic             dz_c;
    logic             ovf_c;
    logic [WIDTH-1:0] quo_special_c;
    logic [WIDTH-1:0] rem_special_c;

    assign op_c     = div_op_t'(op);
    assign accept_c = in_valid && in_ready;
    assign signed_c = (op_c == OP_DIV) || (op_c == OP_REM);
    assign neg_a_c  = signed_c && dividend[WIDTH-1];
    assign neg_b_c  = signed_c && divisor[WIDTH-1];
    assign mag_a_c  = neg_a_c ? (~dividend + WIDTH'(1)) : dividend;
    assign mag_b_c  = neg_b_c ? (~divisor + WIDTH'(1)) : divisor;
    assign dz_c     = (divisor == '0);
    assign ovf_c    = signed_c && (dividend == INT_MIN) && (divisor == '1);

    assign quo_special_c = dz_c ? DIV_ZERO_QUO : INT_MIN;
    assign rem_special_c = dz_c ? dividend : '0;

    // Sign correction applied in FIX; sign flags are already zero for unsigned ops
    logic             is_rem_q;
    logic [WIDTH-1:0] quo_fix_c;
    logic [WIDTH-1:0] rem_fix_c;

    assign is_rem_q  = (op_q == OP_REM) || (op_q == OP_REMU);
    assign quo_fix_c = (sign_a ^ sign_b) ? (~quo_q + WIDTH'(1)) : quo_q;
    assign rem_fix_c = sign_a ? (~rem_q + WIDTH'(1)) : rem_q;

`ifdef SEQ_DIVIDER_EARLY_OUT_EN
    localparam int unsigned LZ_W = CNT_W + 1;

    function automatic logic [LZ_W-1:0] lzc(input logic [WIDTH-1:0] v);
        lzc = LZ_W'(WIDTH);
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (v[i]) lzc = LZ_W'(int'(WIDTH) - 1 - i);
        end
    endfunction

    logic [LZ_W-1:0] lz_c;
    assign lz_c = lzc(mag_a_c);
`endif

    // Control FSM and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            op_q        <= OP_DIV;
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
            rem_q       <= '0;
            quo_q       <= '0;
            dsr_q       <= '0;
            cnt_q       <= '0;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            result      <= '0;
            div_by_zero <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        in_ready <= 1'b0;
                        op_q     <= op_c;
                        sign_a   <= neg_a_c;
                        sign_b   <= neg_b_c;
                        dsr_q    <= mag_b_c;
                        rem_q    <= '0;
                        cnt_q    <= '0;
                        if (dz_c || ovf_c) begin
                            // Resolved without iterating
                            quo_q       <= '0;
                            result      <= op_c[1] ? rem_special_c : quo_special_c;
                            div_by_zero <= dz_c;
                            state       <= DONE;
                        end else begin
                            busy <= 1'b1;
`ifdef SEQ_DIVIDER_EARLY_OUT_EN
                            if (mag_a_c == '0) begin
                                quo_q <= '0;
                                state <= FIX;
                            end else begin
                                // Leading zeros only ever shift in zero quotient bits
                                quo_q <= mag_a_c << lz_c;
                                cnt_q <= lz_c[CNT_W-1:0];
                                state <= BUSY;
                            end
`else
                            quo_q <= mag_a_c;
                            state <= BUSY;
`endif
                        end
                    end
                end
                BUSY: begin
                    rem_q <= step_rem;
                    quo_q <= {quo_q[WIDTH-2:0], step_bit};
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) state <= FIX;
                end
                FIX: begin
                    result      <= is_rem_q ? rem_fix_c : quo_fix_c;
                    div_by_zero <= 1'b0;
                    busy        <= 1'b0;
                    state       <= DONE;
                end
                DONE: begin
                    // out_valid follows one edge after entering DONE
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
